// File: rtl/div_disp_pkg.sv
// Shared types and constants for the divider result display.
//   - FSM state encoding
//   - 4-bit digit codes (decimal digits, error letters, blank)
//   - active-high gfedcba segment patterns per digit code
//   - double-dabble step helper used by the converter
package div_disp_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned NUM_SHIFTS = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    CONVERT = 2'd2,
    SHOW    = 2'd3
  } state_t;

  typedef enum logic [3:0] {
    D0     = 4'd0,
    D1     = 4'd1,
    D2     = 4'd2,
    D3     = 4'd3,
    D4     = 4'd4,
    D5     = 4'd5,
    D6     = 4'd6,
    D7     = 4'd7,
    D8     = 4'd8,
    D9     = 4'd9,
    DE     = 4'd10,
    DR     = 4'd11,
    DO     = 4'd12,
    DBLANK = 4'd13
  } digit_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_R     = 7'h50;
  localparam logic [6:0] SEG_O     = 7'h5C;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // One double-dabble step on {units_bcd, binary}: add-3 fix on the BCD
  // nibble, then shift left. Bit 8 of the result is the bit shifted out,
  // which is the tens carry.
  function automatic logic [8:0] dd_step(input logic [7:0] v);
    logic [7:0] a;
    a = v;
    if (v[7:4] >= 4'd5) a[7:4] = v[7:4] + 4'd3;
    return {a, 1'b0};
  endfunction

endpackage

// File: rtl/seg7_encoder.sv
// Digit code to 7-segment pattern (active-high, seg[0]=a .. seg[6]=g).
//   i_digit : digit code
//   o_seg   : active-high segment pattern; polarity handled by the parent
module seg7_encoder
  import div_disp_pkg::*;
(
  input  digit_t     i_digit,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_digit)
      D0:      o_seg = SEG_0;
      D1:      o_seg = SEG_1;
      D2:      o_seg = SEG_2;
      D3:      o_seg = SEG_3;
      D4:      o_seg = SEG_4;
      D5:      o_seg = SEG_5;
      D6:      o_seg = SEG_6;
      D7:      o_seg = SEG_7;
      D8:      o_seg = SEG_8;
      D9:      o_seg = SEG_9;
      DE:      o_seg = SEG_E;
      DR:      o_seg = SEG_R;
      DO:      o_seg = SEG_O;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/div_result_display.sv
// Divider result display: accepts quotient/remainder/error via valid/ready,
// converts both to BCD with a 4-step double dabble, and scans a 4-digit
// multiplexed 7-segment display (Q tens, Q units, R tens, R units).
// Divide-by-zero shows "Erro".
//   clk, rst        : clock, asynchronous active-high reset
//   in_valid/ready  : input handshake; ready only in IDLE/SHOW
//   quo, rem_in, err: divider result
//   busy            : high while loading/converting
//   seg, an, dp     : display drive, polarity set by ACTIVE_LOW
// Build option: BLANK_LEADING_ZERO_EN blanks a zero tens digit.
module div_result_display
  import div_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] quo,
  input  logic [3:0] rem_in,
  input  logic       err,
  output logic       busy,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [1:0] LAST_SHIFT = 2'(NUM_SHIFTS - 1);

  state_t           r_state;
  logic             r_in_ready;
  logic             r_busy;
  logic [3:0]       r_quo_cap;
  logic [3:0]       r_rem_cap;
  logic             r_err_cap;
  logic [7:0]       r_q_dd;
  logic [7:0]       r_r_dd;
  logic             r_q_tens;
  logic             r_r_tens;
  logic [1:0]       r_shift_cnt;
  digit_t           r_digit [NUM_DIGITS];
  logic [CNT_W-1:0] r_scan_cnt;
  logic [1:0]       r_idx;
  logic [6:0]       r_seg;
  logic [3:0]       r_an;

  logic       w_accept;
  logic [8:0] w_q_step;
  logic [8:0] w_r_step;
  logic       w_q_tens;
  logic       w_r_tens;
  digit_t     w_q_tens_dig;
  digit_t     w_r_tens_dig;
  digit_t     w_q_units_dig;
  digit_t     w_r_units_dig;
  logic [1:0] w_sel;
  logic [6:0] w_seg_pat;

  assign w_accept = in_valid & r_in_ready;

  // Next double-dabble step and the final digit codes it would produce.
  always_comb begin
    w_q_step      = dd_step(r_q_dd);
    w_r_step      = dd_step(r_r_dd);
    w_q_tens      = r_q_tens | w_q_step[8];
    w_r_tens      = r_r_tens | w_r_step[8];
    w_q_units_dig = digit_t'(w_q_step[7:4]);
    w_r_units_dig = digit_t'(w_r_step[7:4]);
`ifdef BLANK_LEADING_ZERO_EN
    w_q_tens_dig  = w_q_tens ? D1 : DBLANK;
    w_r_tens_dig  = w_r_tens ? D1 : DBLANK;
`else
    w_q_tens_dig  = w_q_tens ? D1 : D0;
    w_r_tens_dig  = w_r_tens ? D1 : D0;
`endif
  end

  // Handshake / conversion FSM; digit registers only change on completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_quo_cap   <= 4'd0;
      r_rem_cap   <= 4'd0;
      r_err_cap   <= 1'b0;
      r_q_dd      <= 8'd0;
      r_r_dd      <= 8'd0;
      r_q_tens    <= 1'b0;
      r_r_tens    <= 1'b0;
      r_shift_cnt <= 2'd0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) r_digit[i] <= DBLANK;
    end else begin
      case (r_state)
        IDLE, SHOW: begin
          if (w_accept) begin
            r_quo_cap  <= quo;
            r_rem_cap  <= rem_in;
            r_err_cap  <= err;
            r_state    <= LOAD;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        LOAD: begin
          r_q_dd      <= {4'd0, r_quo_cap};
          r_r_dd      <= {4'd0, r_rem_cap};
          r_q_tens    <= 1'b0;
          r_r_tens    <= 1'b0;
          r_shift_cnt <= 2'd0;
          if (r_err_cap) begin
            r_digit[3] <= DE;
            r_digit[2] <= DR;
            r_digit[1] <= DR;
            r_digit[0] <= DO;
            r_state    <= SHOW;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
          end else begin
            r_state <= CONVERT;
          end
        end
        CONVERT: begin
          r_q_dd      <= w_q_step[7:0];
          r_r_dd      <= w_r_step[7:0];
          r_q_tens    <= w_q_tens;
          r_r_tens    <= w_r_tens;
          r_shift_cnt <= r_shift_cnt + 2'd1;
          if (r_shift_cnt == LAST_SHIFT) begin
            r_digit[3] <= w_q_tens_dig;
            r_digit[2] <= w_q_units_dig;
            r_digit[1] <= w_r_tens_dig;
            r_digit[0] <= w_r_units_dig;
            r_state    <= SHOW;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b1;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  // Scan index i drives an[3-i] with digit register 3-i (leftmost first).
  assign w_sel = ~r_idx;

  seg7_encoder u_enc (
    .i_digit (r_digit[w_sel]),
    .o_seg   (w_seg_pat)
  );

  // Free-running scan; anode and pattern are registered together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan_cnt <= '0;
      r_idx      <= 2'd0;
      r_seg      <= {7{ACTIVE_LOW}};
      r_an       <= {4{ACTIVE_LOW}};
    end else begin
      if (r_scan_cnt == CNT_MAX) begin
        r_scan_cnt <= '0;
        r_idx      <= r_idx + 2'd1;
      end else begin
        r_scan_cnt <= r_scan_cnt + CNT_W'(1);
      end
      r_seg <= ACTIVE_LOW ? ~w_seg_pat : w_seg_pat;
      r_an  <= ACTIVE_LOW ? ~(4'b1000 >> r_idx) : (4'b1000 >> r_idx);
    end
  end

  assign in_ready = r_in_ready;
  assign busy     = r_busy;
  assign seg      = r_seg;
  assign an       = r_an;
  assign dp       = ACTIVE_LOW;

endmodule

// File: tb/tb_div_result_display.sv
`timescale 1ns/1ps
module tb_div_result_display;

  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid;
  logic [3:0] quo;
  logic [3:0] rem_in;
  logic       err;

  logic [NI-1:0] rdy_w;
  logic [NI-1:0] busy_w;
  logic [NI-1:0] dp_w;
  logic [6:0]    seg_w [NI];
  logic [3:0]    an_w  [NI];

  always #5 clk = ~clk;

  div_result_display #(.SCAN_DIV(4), .ACTIVE_LOW(1'b1)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_w[0]),
    .quo(quo), .rem_in(rem_in), .err(err), .busy(busy_w[0]),
    .seg(seg_w[0]), .an(an_w[0]), .dp(dp_w[0]));

  div_result_display #(.SCAN_DIV(1), .ACTIVE_LOW(1'b1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_w[1]),
    .quo(quo), .rem_in(rem_in), .err(err), .busy(busy_w[1]),
    .seg(seg_w[1]), .an(an_w[1]), .dp(dp_w[1]));

  div_result_display #(.SCAN_DIV(3), .ACTIVE_LOW(1'b0)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_w[2]),
    .quo(quo), .rem_in(rem_in), .err(err), .busy(busy_w[2]),
    .seg(seg_w[2]), .an(an_w[2]), .dp(dp_w[2]));

  function automatic int sd_of(input int k);
    case (k)
      0:       return 4;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  function automatic bit al_of(input int k);
    return (k != 2);
  endfunction

  // Digit symbols: 0..9 decimal, 10=E, 11=r, 12=o, 13=blank.
  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;  10: return 7'h79; 11: return 7'h50;
      12: return 7'h5C; default: return 7'h00;
    endcase
  endfunction

  int n_cmp = 0;
  int n_mis = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      if (n_mis <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_mis++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  int m_dig  [4];   // [3] = Q tens ... [0] = R units
  int m_pend [4];
  int m_lock;       // cycles until the block is ready again
  int m_cyc;        // clock edges since reset release
  logic [6:0] exp_seg [NI];
  logic [3:0] exp_an  [NI];
  logic       exp_busy;
  logic       exp_rdy;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_dig[i]  = 13;
      m_pend[i] = 13;
    end
    m_lock   = 0;
    m_cyc    = 0;
    exp_busy = 1'b0;
    exp_rdy  = 1'b1;
    for (int k = 0; k < NI; k++) begin
      exp_seg[k] = al_of(k) ? 7'h7F : 7'h00;
      exp_an[k]  = al_of(k) ? 4'hF : 4'h0;
    end
  endfunction

  function automatic void model_result(input int q, input int r, input bit e);
    if (e) begin
      m_pend[3] = 10; m_pend[2] = 11; m_pend[1] = 11; m_pend[0] = 12;
    end else begin
      m_pend[3] = q / 10; m_pend[2] = q % 10;
      m_pend[1] = r / 10; m_pend[0] = r % 10;
`ifdef BLANK_LEADING_ZERO_EN
      if (m_pend[3] == 0) m_pend[3] = 13;
      if (m_pend[1] == 0) m_pend[1] = 13;
`endif
    end
  endfunction

  function automatic logic [15:0] pack_dig();
    return {4'(m_dig[3]), 4'(m_dig[2]), 4'(m_dig[1]), 4'(m_dig[0])};
  endfunction

  initial begin
    bit         rdy_before;
    int         idx;
    logic [6:0] pat;
    logic [3:0] anh;
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        model_reset();
      end else begin
        rdy_before = (m_lock == 0);
        // Display output after this edge reflects position and digits before it.
        for (int k = 0; k < NI; k++) begin
          idx = (m_cyc / sd_of(k)) % 4;
          pat = seg_of(m_dig[3 - idx]);
          anh = 4'b1000 >> idx;
          exp_an[k]  = al_of(k) ? ~anh : anh;
          exp_seg[k] = al_of(k) ? ~pat : pat;
        end
        m_cyc++;
        if (m_lock > 0) begin
          m_lock--;
          if (m_lock == 0) m_dig = m_pend;
        end
        if (rdy_before && in_valid) begin
          model_result(int'(quo), int'(rem_in), err);
          m_lock = err ? 1 : 5;
        end
        exp_busy = (m_lock > 0);
        exp_rdy  = (m_lock == 0);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int k = 0; k < NI; k++) begin
          chk($sformatf("u%0d.an", k),       32'(an_w[k]),   32'(exp_an[k]));
          chk($sformatf("u%0d.seg", k),      32'(seg_w[k]),  32'(exp_seg[k]));
          chk($sformatf("u%0d.dp", k),       32'(dp_w[k]),   32'(al_of(k)));
          chk($sformatf("u%0d.busy", k),     32'(busy_w[k]), 32'(exp_busy));
          chk($sformatf("u%0d.in_ready", k), 32'(rdy_w[k]),  32'(exp_rdy));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [3:0] q, input logic [3:0] r, input logic e);
    int n;
    n = 0;
    while (rdy_w[0] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) timeout_fail("send.wait_ready");
    quo = q; rem_in = r; err = e; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_an(input int k, input logic [3:0] target);
    int n;
    n = 0;
    while (an_w[k] !== target && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) timeout_fail($sformatf("wait_an.u%0d.%0h", k, target));
  endtask

  initial begin
    int acc;
    in_valid = 1'b0; quo = 4'd0; rem_in = 4'd0; err = 1'b0;
    #1 rst = 1'b1;
    #1 chk_en = 1'b1;
    #1;
    chk("reset.u0.seg", 32'(seg_w[0]), 32'h7F);
    chk("reset.u0.an",  32'(an_w[0]),  32'hF);
    chk("reset.u2.seg", 32'(seg_w[2]), 32'h00);
    chk("reset.u2.an",  32'(an_w[2]),  32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Q=13, R=2
    send(4'd13, 4'd2, 1'b0);
    repeat (8) @(negedge clk);
`ifdef BLANK_LEADING_ZERO_EN
    chk("model.q13r2", 32'(pack_dig()), 32'h13D2);
`else
    chk("model.q13r2", 32'(pack_dig()), 32'h1302);
`endif
    wait_an(0, 4'b0111); chk("q13r2.qtens",  32'(seg_w[0]), 32'h79);
    wait_an(0, 4'b1011); chk("q13r2.qunits", 32'(seg_w[0]), 32'h30);
    wait_an(0, 4'b1101);
`ifdef BLANK_LEADING_ZERO_EN
    chk("q13r2.rtens", 32'(seg_w[0]), 32'h7F);
`else
    chk("q13r2.rtens", 32'(seg_w[0]), 32'h40);
`endif
    wait_an(0, 4'b1110); chk("q13r2.runits", 32'(seg_w[0]), 32'h24);

    // Divide by zero
    send(4'd0, 4'd0, 1'b1);
    repeat (3) @(negedge clk);
    chk("model.err", 32'(pack_dig()), 32'hABBC);
    wait_an(0, 4'b0111); chk("err.E", 32'(seg_w[0]), 32'h06);
    wait_an(0, 4'b1011); chk("err.r", 32'(seg_w[0]), 32'h2F);
    wait_an(0, 4'b1110); chk("err.o", 32'(seg_w[0]), 32'h23);
    wait_an(2, 4'b1000); chk("err.E.active_high", 32'(seg_w[2]), 32'h79);

    // Boundaries
    send(4'd15, 4'd15, 1'b0);
    repeat (8) @(negedge clk);
    chk("model.q15r15", 32'(pack_dig()), 32'h1515);
    send(4'd0, 4'd0, 1'b0);
    repeat (8) @(negedge clk);
`ifdef BLANK_LEADING_ZERO_EN
    chk("model.q0r0", 32'(pack_dig()), 32'hD0D0);
`else
    chk("model.q0r0", 32'(pack_dig()), 32'h0000);
`endif

    // Reset in the middle of a conversion
    send(4'd9, 4'd0, 1'b0);
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midreset.u0.seg",  32'(seg_w[0]),  32'h7F);
    chk("midreset.u0.an",   32'(an_w[0]),   32'hF);
    chk("midreset.u0.busy", 32'(busy_w[0]), 32'h0);
    chk("midreset.model",   32'(pack_dig()), 32'hDDDD);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    send(4'd9, 4'd0, 1'b0);
    repeat (8) @(negedge clk);
`ifdef BLANK_LEADING_ZERO_EN
    chk("model.after_reset", 32'(pack_dig()), 32'hD9D0);
`else
    chk("model.after_reset", 32'(pack_dig()), 32'h0900);
`endif

    // Back-to-back: in_valid held, data changing every cycle
    acc = 0;
    for (int c = 0; c < 120; c++) begin
      quo      = 4'($urandom_range(0, 15));
      rem_in   = 4'($urandom_range(0, 15));
      err      = 1'b0;
      in_valid = 1'b1;
      if (rdy_w[0] === 1'b1) acc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("b2b.accepts", 32'(acc), 32'd20);
    repeat (8) @(negedge clk);

    // Randomized transactions with idle gaps
    for (int t = 0; t < 25; t++) begin
      send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 4) == 0));
      repeat ($urandom_range(0, 10)) @(negedge clk);
    end
    repeat (30) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
